// File: rtl/riscv_definitions.sv
// rtl/riscv_definitions.sv - shared types and constants for the multiply/divide unit
package riscv_definitions;

   localparam int MD_XLEN = 32;

   // Operation codes use the RV32M funct3 encoding
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_ops_t;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_DONE = 2'd2
   } md_state_t;

   localparam logic [MD_XLEN-1:0] MD_DIV_ZERO_Q = '1;
   localparam logic [MD_XLEN-1:0] MD_INT_MIN    = {1'b1, {(MD_XLEN-1){1'b0}}};

   // rs1 is treated as signed by every op except the fully unsigned ones
   function automatic logic md_a_signed(input md_ops_t op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_MULHSU) ||
             (op == MD_DIV) || (op == MD_REM);
   endfunction

   // rs2 is signed only for the fully signed ops
   function automatic logic md_b_signed(input md_ops_t op);
      return (op == MD_MUL) || (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic md_is_div(input md_ops_t op);
      return op[2];
   endfunction

endpackage

// File: rtl/md_sign_fix.sv
// rtl/md_sign_fix.sv - conditional two's-complement negation for operand magnitudes and results
module md_sign_fix #(
   parameter int W = 32
) (
   input  logic [W-1:0] val_i,
   input  logic         neg_i,
   output logic [W-1:0] res_o
);

   // Negate when asked; used both to take |x| of operands and to restore result signs
   always_comb begin
      res_o = neg_i ? (~val_i + 1'b1) : val_i;
   end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 RV32M multiply/divide unit
module muldiv_unit
   import riscv_definitions::*;
#(
   parameter int XLEN = MD_XLEN
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  md_ops_t         req_op,
   input  logic [XLEN-1:0] req_a,
   input  logic [XLEN-1:0] req_b,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            busy
);

   localparam int CW = $clog2(XLEN) + 1;

   md_state_t         state_q, state_d;
   md_ops_t           op_q, op_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   b_q, b_d;
   logic              sign_a_q, sign_a_d;
   logic              sign_b_q, sign_b_d;
   logic              resp_valid_q, resp_valid_d;
   logic [XLEN-1:0]   result_q, result_d;

   logic              neg_a, neg_b;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [2*XLEN-1:0] acc_step;
   logic [XLEN:0]     mul_sum, rem_sh;
   logic              div_ge;
   logic [2*XLEN-1:0] prod_fix;
   logic [XLEN-1:0]   quo_fix, rem_fix, res_sel;

   assign neg_a = md_a_signed(req_op) & req_a[XLEN-1];
   assign neg_b = md_b_signed(req_op) & req_b[XLEN-1];

   md_sign_fix #(.W(XLEN)) u_mag_a (.val_i(req_a), .neg_i(neg_a), .res_o(mag_a));
   md_sign_fix #(.W(XLEN)) u_mag_b (.val_i(req_b), .neg_i(neg_b), .res_o(mag_b));

   // One iteration: shift-add for multiply ({hi, multiplier}), restoring step for divide ({rem, dividend})
   always_comb begin
      mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
      rem_sh  = acc_q[2*XLEN-1:XLEN-1];
      div_ge  = rem_sh >= {1'b0, b_q};
      if (md_is_div(op_q)) begin
         acc_step = {(div_ge ? XLEN'(rem_sh - {1'b0, b_q}) : rem_sh[XLEN-1:0]),
                     acc_q[XLEN-2:0], div_ge};
      end else begin
         acc_step = {mul_sum, acc_q[XLEN-1:1]};
      end
   end

   md_sign_fix #(.W(2*XLEN)) u_fix_prod (.val_i(acc_step), .neg_i(sign_a_q ^ sign_b_q), .res_o(prod_fix));
   md_sign_fix #(.W(XLEN)) u_fix_quo (.val_i(acc_step[XLEN-1:0]), .neg_i(sign_a_q ^ sign_b_q), .res_o(quo_fix));
   md_sign_fix #(.W(XLEN)) u_fix_rem (.val_i(acc_step[2*XLEN-1:XLEN]), .neg_i(sign_a_q), .res_o(rem_fix));

   // Pick the half or quantity the latched op asks for
   always_comb begin
      case (op_q)
         MD_MUL:                       res_sel = prod_fix[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: res_sel = prod_fix[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              res_sel = quo_fix;
         default:                      res_sel = rem_fix;
      endcase
   end

   // Next-state logic: accept and short-circuit special divides, iterate, hold result until taken
   always_comb begin
      state_d      = state_q;
      op_d         = op_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      b_d          = b_q;
      sign_a_d     = sign_a_q;
      sign_b_d     = sign_b_q;
      resp_valid_d = resp_valid_q;
      result_d     = result_q;
      case (state_q)
         MD_IDLE: begin
            if (req_valid) begin
               op_d     = req_op;
               sign_a_d = neg_a;
               sign_b_d = neg_b;
               acc_d    = {{XLEN{1'b0}}, mag_a};
               b_d      = mag_b;
               if (md_is_div(req_op) && (req_b == '0)) begin
                  result_d     = req_op[1] ? req_a : MD_DIV_ZERO_Q;
                  resp_valid_d = 1'b1;
                  state_d      = MD_DONE;
               end else if (md_is_div(req_op) && !req_op[0] &&
                            (req_a == MD_INT_MIN) && (req_b == '1)) begin
                  result_d     = req_op[1] ? '0 : MD_INT_MIN;
                  resp_valid_d = 1'b1;
                  state_d      = MD_DONE;
               end else begin
                  cnt_d   = CW'(XLEN);
                  state_d = MD_CALC;
               end
            end
         end
         MD_CALC: begin
            cnt_d = cnt_q - 1'b1;
            acc_d = acc_step;
            if (cnt_q == CW'(1)) begin
               result_d     = res_sel;
               resp_valid_d = 1'b1;
               state_d      = MD_DONE;
            end
         end
         MD_DONE: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               state_d      = MD_IDLE;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
            state_d      = MD_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight request
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= MD_IDLE;
         op_q         <= MD_MUL;
         cnt_q        <= '0;
         acc_q        <= '0;
         b_q          <= '0;
         sign_a_q     <= 1'b0;
         sign_b_q     <= 1'b0;
         resp_valid_q <= 1'b0;
         result_q     <= '0;
      end else begin
         state_q      <= state_d;
         op_q         <= op_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         b_q          <= b_d;
         sign_a_q     <= sign_a_d;
         sign_b_q     <= sign_b_d;
         resp_valid_q <= resp_valid_d;
         result_q     <= result_d;
      end
   end

   assign req_ready   = (state_q == MD_IDLE);
   assign busy        = (state_q != MD_IDLE);
   assign resp_valid  = resp_valid_q;
   assign resp_result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;
   import riscv_definitions::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   md_ops_t     req_op = MD_MUL;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic        resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_result;
   logic        busy;

   int tests = 0;
   int fails = 0;

   muldiv_unit #(.XLEN(32)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_result(resp_result),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference results straight from the RV32M definitions
   function automatic logic [31:0] ref_model(input md_ops_t op, input logic [31:0] a, input logic [31:0] b);
      longint sa = longint'($signed(a));
      longint sb = longint'($signed(b));
      longint ua = longint'({32'b0, a});
      longint ub = longint'({32'b0, b});
      logic [63:0] p;
      case (op)
         MD_MUL:    begin p = sa * sb; return p[31:0];  end
         MD_MULH:   begin p = sa * sb; return p[63:32]; end
         MD_MULHSU: begin p = sa * ub; return p[63:32]; end
         MD_MULHU:  begin p = ua * ub; return p[63:32]; end
         MD_DIV: begin
            if (b == 0) return 32'hFFFF_FFFF;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
            return $signed(a) / $signed(b);
         end
         MD_DIVU: begin
            if (b == 0) return 32'hFFFF_FFFF;
            return a / b;
         end
         MD_REM: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
            return $signed(a) % $signed(b);
         end
         default: begin
            if (b == 0) return a;
            return a % b;
         end
      endcase
   endfunction

   function automatic int ref_latency(input md_ops_t op, input logic [31:0] a, input logic [31:0] b);
      if (op >= MD_DIV && b == 0) return 0;
      if ((op == MD_DIV || op == MD_REM) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
      return 32;
   endfunction

   // Issue one request, measure latency, optionally stall the response, then complete the handshake
   task automatic run_op(input string tag, input md_ops_t op, input logic [31:0] a, input logic [31:0] b,
                         input int stall);
      logic [31:0] exp_res;
      int          edges;
      logic        ready_seen;
      exp_res    = ref_model(op, a, b);
      ready_seen = 1'b0;
      @(negedge clk);
      check({tag, ".req_ready_idle"}, req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      edges = 0;
      while (!resp_valid && edges < 100) begin
         if (req_ready) ready_seen = 1'b1;
         @(posedge clk);
         #1;
         edges++;
      end
      check({tag, ".latency"}, edges, ref_latency(op, a, b));
      check({tag, ".result"}, resp_result, exp_res);
      check({tag, ".req_ready_low"}, ready_seen | req_ready, 1'b0);
      for (int i = 0; i < stall; i++) begin
         @(negedge clk);
         req_valid = (i == 3);
         req_op    = MD_MUL;
         req_a     = 32'd5;
         req_b     = 32'd5;
         @(posedge clk);
         #1;
         req_valid = 1'b0;
         check({tag, ".stall_valid"}, resp_valid, 1'b1);
         check({tag, ".stall_result"}, resp_result, exp_res);
         check({tag, ".stall_busy"}, busy, 1'b1);
      end
      @(negedge clk);
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      check({tag, ".resp_valid_cleared"}, resp_valid, 1'b0);
      check({tag, ".req_ready_back"}, req_ready, 1'b1);
   endtask

   initial begin
      md_ops_t     op;
      logic [31:0] a, b;

      repeat (2) @(posedge clk);
      #1;
      check("reset.req_ready", req_ready, 1'b1);
      check("reset.resp_valid", resp_valid, 1'b0);
      check("reset.resp_result", resp_result, 32'h0);
      check("reset.busy", busy, 1'b0);
      @(negedge clk);
      reset = 1'b1;

      run_op("mul_7_m3", MD_MUL, 32'd7, 32'hFFFF_FFFD, 0);
      check("mul_7_m3.abs", resp_result, 32'hFFFF_FFEB);
      run_op("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 0);
      check("mulh_min.abs", resp_result, 32'h4000_0000);
      run_op("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("mulhu_max.abs", resp_result, 32'hFFFF_FFFE);
      run_op("mulhsu_m1", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
      check("mulhsu_m1.abs", resp_result, 32'hFFFF_FFFF);
      run_op("div_m20_6", MD_DIV, 32'hFFFF_FFEC, 32'd6, 0);
      check("div_m20_6.abs", resp_result, 32'hFFFF_FFFD);
      run_op("rem_m20_6", MD_REM, 32'hFFFF_FFEC, 32'd6, 0);
      check("rem_m20_6.abs", resp_result, 32'hFFFF_FFFE);
      run_op("divu_20_6", MD_DIVU, 32'd20, 32'd6, 0);
      check("divu_20_6.abs", resp_result, 32'd3);
      run_op("remu_20_6", MD_REMU, 32'd20, 32'd6, 0);
      check("remu_20_6.abs", resp_result, 32'd2);
      run_op("divu_by0", MD_DIVU, 32'd123, 32'd0, 0);
      check("divu_by0.abs", resp_result, 32'hFFFF_FFFF);
      run_op("rem_by0", MD_REM, 32'd123, 32'd0, 0);
      check("rem_by0.abs", resp_result, 32'd123);
      run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("div_ovf.abs", resp_result, 32'h8000_0000);
      run_op("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
      check("rem_ovf.abs", resp_result, 32'h0);
      run_op("mul_x0", MD_MUL, 32'h1234_5678, 32'd0, 0);
      run_op("div_stall", MD_DIV, 32'd100, 32'd7, 10);
      check("div_stall.abs", resp_result, 32'd14);

      // Asynchronous reset in the middle of a divide, with the counter at 10
      @(negedge clk);
      req_valid = 1'b1;
      req_op    = MD_DIV;
      req_a     = 32'd1000;
      req_b     = 32'd3;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      repeat (22) @(posedge clk);
      #3;
      reset = 1'b0;
      #1;
      check("async_rst.resp_valid", resp_valid, 1'b0);
      check("async_rst.resp_result", resp_result, 32'h0);
      check("async_rst.busy", busy, 1'b0);
      check("async_rst.req_ready", req_ready, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      run_op("mul_after_rst", MD_MUL, 32'd6, 32'd7, 0);
      check("mul_after_rst.abs", resp_result, 32'd42);

      for (int i = 0; i < 40; i++) begin
         op = md_ops_t'($urandom_range(0, 7));
         a  = $urandom;
         b  = $urandom;
         case ($urandom_range(0, 5))
            0: b = 32'h0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: b = $urandom_range(1, 15);
            3: a = $urandom_range(0, 300);
            default: ;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, op), op, a, b, (i % 8 == 0) ? 2 : 0);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide unit.
- Acts as the responder to the execute stage: accepts one request (op, two operands) over a valid/ready handshake and returns one result over a second valid/ready handshake.
- Sits beside the single-cycle ALU in the execute stage.
- Radix-2: one partial-product or quotient bit per cycle; one request in flight at a time.

Parameters:
- XLEN, 32, operand/result width; counter width is $clog2(XLEN)+1.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset (asserted when 0)
- req_valid  input  1  request present
- req_ready  output  1  unit can accept a request; high only in IDLE
- req_op  input  md_ops_t (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU (encoding = funct3)
- req_a  input  XLEN  rs1 operand
- req_b  input  XLEN  rs2 operand
- resp_valid  output  1  result available
- resp_ready  input  1  consumer takes result
- resp_result  output  XLEN  result
- busy  output  1  high in CALC or DONE

Behaviour:
- States: IDLE, CALC, DONE, held in md_state_t.
- Reset (any time, including mid-CALC or in DONE): state=IDLE, resp_valid=0, resp_result=0, counter=0, internal accumulators=0. The in-flight request is discarded. req_ready follows the state, so it is high when reset releases.
- IDLE:
  - req_ready=1. Accept when req_valid is high at a rising edge.
  - On accept: latch op; take operand magnitudes (negate if signed per op and MSB set); record sign_a, sign_b.
- Signedness per op:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: a signed, b unsigned.
  - MULHU, DIVU, REMU: both unsigned.
- Special cases, checked at accept; go straight to DONE, so resp_valid is high after 1 edge:
  - b==0, DIV/DIVU: result all-ones.
  - b==0, REM/REMU: result = a.
  - Signed overflow (DIV/REM with a==0x80000000, b==0xFFFFFFFF): DIV result 0x80000000; REM result 0.
  - Multiplies have no special cases; x*0 takes the full latency.
- CALC, counter = XLEN down to 1, decremented each edge:
  - Multiply: 2*XLEN accumulator. If the multiplier LSB is set, add the multiplicand to the upper half; then shift right 1.
  - Divide: restoring. Shift {rem, dividend} left 1; if rem >= divisor, subtract and set quotient bit.
  - On the edge where the counter reaches 0: apply sign correction combinationally and register resp_result, then enter DONE.
- Sign correction:
  - Product: negated if sign_a^sign_b.
  - Quotient: negated if sign_a^sign_b.
  - Remainder: takes sign_a.
- Result selection:
  - MUL: product low half. MULH/MULHSU/MULHU: product high half.
  - DIV/DIVU: quotient. REM/REMU: remainder.
- Latency: accept at edge k, resp_valid high after edge k+XLEN for normal ops.
- DONE:
  - resp_valid=1; resp_result is stable until the handshake.
  - On resp_ready at an edge: go to IDLE and clear resp_valid.
  - req_ready=0 in DONE, so there is no same-cycle accept. Back-to-back throughput is XLEN+2 cycles.
- resp_ready held low: the unit stalls in DONE indefinitely with no loss of data.
- req_valid while not in IDLE: ignored. The initiator must hold the request until req_ready.

Decomposition:
- riscv_definitions package gets:
  - md_ops_t enum (3-bit, funct3 encoding)
  - md_state_t enum
  - constant MD_DIV_ZERO_Q (all-ones)
  - constant MD_INT_MIN (0x80000000)
- One natural sub-module, md_sign_fix: purely combinational operand-magnitude and result-negation helper, instantiated for the input and output sides. The iteration datapath and FSM stay in muldiv_unit.

Test Plan:
1. MUL a=7, b=-3 (0xFFFFFFFD), resp_ready=1 -> resp_valid after exactly 32 edges from accept; result 0xFFFFFFEB; req_ready low throughout.
2. MULH a=0x80000000, b=0x80000000 -> 0x40000000. MULHU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=-1, b=0xFFFFFFFF -> 0xFFFFFFFF.
3. DIV a=-20, b=6 -> 0xFFFFFFFD (-3). REM a=-20, b=6 -> 0xFFFFFFFE (-2). DIVU a=20, b=6 -> 3. REMU a=20, b=6 -> 2.
4. DIVU a=123, b=0 -> 0xFFFFFFFF after 1 edge. REM a=123, b=0 -> 123. DIV a=0x80000000, b=-1 -> 0x80000000. REM of the same operands -> 0.
5. DIV 100/7 with resp_ready held low 10 cycles after resp_valid -> resp_valid and result 14 stable; new req_valid ignored; handshake returns to IDLE with req_ready=1 next cycle.
6. Assert reset at counter=10 mid-DIV -> resp_valid=0, resp_result=0, busy=0 immediately (asynchronous). After release, MUL 6*7 -> 42 with normal latency.
